// File: rtl/cjb_nbit_skid_reg_v.sv
// n-bit pipeline stage with valid/ready handshake and a one-entry skid buffer.
// in_ready is registered, so out_ready never reaches in_ready combinationally.
module cjb_nbit_skid_reg_v #(
   parameter int unsigned        n          = 8,
   parameter logic [n-1:0]       RESET_DATA = '0
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         flush,
   input  logic [n-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [n-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t         state_r;
   state_t         state_s;
   logic [n-1:0]   main_r;
   logic [n-1:0]   main_s;
   logic [n-1:0]   skid_r;
   logic [n-1:0]   skid_s;
   logic           in_ready_r;
   logic           out_valid_r;
   logic [1:0]     occupancy_r;
   logic           accept_s;
   logic           emit_s;

   assign accept_s  = in_valid & in_ready_r;
   assign emit_s    = out_valid_r & out_ready;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = main_r;
   assign occupancy = occupancy_r;

   // Next state and data registers; flush outranks both accept and emit.
   always_comb begin
      state_s = state_r;
      main_s  = main_r;
      skid_s  = skid_r;
      if (flush) begin
         state_s = EMPTY;
         main_s  = RESET_DATA;
         skid_s  = RESET_DATA;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  state_s = ONE;
                  main_s  = in_data;
               end else begin
                  state_s = EMPTY;
               end
            end
            ONE: begin
               if (accept_s && emit_s) begin
                  state_s = ONE;
                  main_s  = in_data;
               end else if (accept_s) begin
                  state_s = TWO;
                  skid_s  = in_data;
               end else if (emit_s) begin
                  state_s = EMPTY;
                  main_s  = RESET_DATA;
               end else begin
                  state_s = ONE;
               end
            end
            TWO: begin
               // in_ready is low here, so only an emit can move the state
               if (emit_s) begin
                  state_s = ONE;
                  main_s  = skid_r;
                  skid_s  = RESET_DATA;
               end else begin
                  state_s = TWO;
               end
            end
            default: begin
               state_s = EMPTY;
               main_s  = RESET_DATA;
               skid_s  = RESET_DATA;
            end
         endcase
      end
   end

   // State and storage registers.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r <= EMPTY;
         main_r  <= RESET_DATA;
         skid_r  <= RESET_DATA;
      end else begin
         state_r <= state_s;
         main_r  <= main_s;
         skid_r  <= skid_s;
      end
   end

   // Handshake and occupancy outputs, registered from the next state.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         occupancy_r <= 2'd0;
      end else begin
         in_ready_r  <= (state_s != TWO);
         out_valid_r <= (state_s != EMPTY);
         case (state_s)
            EMPTY:   occupancy_r <= 2'd0;
            ONE:     occupancy_r <= 2'd1;
            TWO:     occupancy_r <= 2'd2;
            default: occupancy_r <= 2'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_cjb_nbit_skid_reg_v.sv
// Bench for cjb_nbit_skid_reg_v: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cjb_nbit_skid_reg_v;

   localparam int         N  = 8;
   localparam logic [7:0] RD = 8'hC3;

   logic         Clock;
   logic         Resetn;
   logic         flush;
   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   occupancy;

   int errors = 0;
   int checks = 0;
   logic [N-1:0] mq[$];

   cjb_nbit_skid_reg_v #(.n(N), .RESET_DATA(RD)) dut (
      .Clock(Clock), .Resetn(Resetn), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .occupancy(occupancy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a two-deep FIFO; drive inputs, take the edge, advance the model.
   task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
      bit acc;
      bit em;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge Clock);
      acc = in_valid && (mq.size() < 2);
      em  = (mq.size() > 0) && out_ready;
      if (!Resetn || flush) begin
         mq.delete();
      end else begin
         if (em) void'(mq.pop_front());
         if (acc) mq.push_back(in_data);
      end
      #1;
   endtask

   task automatic fill_two();
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b0);
   endtask

   // Compare DUT against the model on every falling edge.
   initial begin
      forever begin
         @(negedge Clock);
         chk("cmp_out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
         chk("cmp_in_ready", int'(in_ready), (mq.size() < 2) ? 1 : 0);
         chk("cmp_occupancy", int'(occupancy), mq.size());
         chk("cmp_out_data", int'(out_data), (mq.size() > 0) ? int'(mq[0]) : int'(RD));
      end
   end

   initial begin
      Resetn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
      // Reset held with in_valid high
      step(1'b1, 8'h55, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_occupancy", int'(occupancy), 0);
      chk("rst_out_data", int'(out_data), 8'hC3);
      @(negedge Clock);
      #2 Resetn = 1'b1;

      // Streaming at full throughput
      step(1'b1, 8'h01, 1'b1, 1'b0);
      chk("stream_1", int'(out_data), 8'h01);
      step(1'b1, 8'h02, 1'b1, 1'b0);
      chk("stream_2", int'(out_data), 8'h02);
      step(1'b1, 8'h03, 1'b1, 1'b0);
      chk("stream_3", int'(out_data), 8'h03);
      chk("stream_in_ready", int'(in_ready), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("stream_drained", int'(occupancy), 0);

      // Stall fill, third word refused
      fill_two();
      chk("fill_occ", int'(occupancy), 2);
      chk("fill_in_ready", int'(in_ready), 0);
      chk("fill_data", int'(out_data), 8'hA5);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("fill_refuse_occ", int'(occupancy), 2);
      chk("fill_refuse_data", int'(out_data), 8'hA5);

      // Drain in order
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_second", int'(out_data), 8'h5A);
      chk("drain_in_ready", int'(in_ready), 1);
      chk("drain_occ1", int'(occupancy), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_occ0", int'(occupancy), 0);
      chk("drain_valid", int'(out_valid), 0);

      // Flush beats accept and emit
      fill_two();
      step(1'b1, 8'h33, 1'b1, 1'b1);
      chk("flush_occ", int'(occupancy), 0);
      chk("flush_valid", int'(out_valid), 0);
      chk("flush_in_ready", int'(in_ready), 1);
      chk("flush_data", int'(out_data), 8'hC3);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("flush_no_33", int'(out_data == 8'h33), 0);

      // Asynchronous reset between edges
      fill_two();
      @(negedge Clock);
      #1 Resetn = 1'b0;
      mq.delete();
      #1;
      chk("areset_valid", int'(out_valid), 0);
      chk("areset_in_ready", int'(in_ready), 1);
      chk("areset_occ", int'(occupancy), 0);
      chk("areset_data", int'(out_data), 8'hC3);
      #1 Resetn = 1'b1;
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("areset_77_data", int'(out_data), 8'h77);
      chk("areset_77_valid", int'(out_valid), 1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 3) != 0), 8'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge Clock);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
